// File: rtl/spi_master_param.sv
// Parametrised SPI master: four CPOL/CPHA modes, fixed sck divider, per-transfer length, NUM_SS selects.
// Define SPI_LSB_FIRST_EN to add the lsb_first port (LSB-first transfers); default build is MSB-first only.

module spi_master_param #(
    parameter  int DATA_W  = 16,
    parameter  int NUM_SS  = 4,
    parameter  int CLK_DIV = 2,
    localparam int LEN_W   = $clog2(DATA_W),
    localparam int SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [LEN_W-1:0]  xfer_len,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [SEL_W-1:0]  ss_sel,
`ifdef SPI_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic              miso,
    output logic              sck,
    output logic              mosi,
    output logic [NUM_SS-1:0] ss,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = LEN_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic [NUM_SS-1:0]   ss_q, ss_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;

    logic                start_lsb, run_lsb;
`ifdef SPI_LSB_FIRST_EN
    logic                lsb_q, lsb_d;
    assign start_lsb = lsb_first;
    assign run_lsb   = lsb_q;
`else
    assign start_lsb = 1'b0;
    assign run_lsb   = 1'b0;
`endif

    function automatic logic [LEN_W-1:0] step_idx(input logic [LEN_W-1:0] i, input logic up);
        return up ? i + LEN_W'(1) : i - LEN_W'(1);
    endfunction

    logic                tick, leading, last_edge, sample_now, drive_now;
    logic [LEN_W-1:0]    first_idx;
    logic [DATA_W-1:0]   rx_shifted, rx_final;
    logic [NUM_SS-1:0]   ss_dec;

    // Edge k of the transfer is the edge_q+1'th; edge 2n is always trailing and closes XFER.
    assign tick       = (div_q == DIV_W'(CLK_DIV - 1));
    assign leading    = ~edge_q[0];
    assign last_edge  = (edge_q == {len_q, 1'b1});
    assign sample_now = leading ^ cpha_q;
    assign drive_now  = ~sample_now & ~last_edge;
    assign first_idx  = start_lsb ? '0 : xfer_len;
    assign rx_shifted = run_lsb ? {miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso};
    assign rx_final   = run_lsb ? (rx_sh_q >> (LEN_W'(DATA_W - 1) - len_q)) : rx_sh_q;

    // An out-of-range ss_sel matches no index, so every select stays high.
    always_comb begin
        for (int i = 0; i < NUM_SS; i++) begin
            ss_dec[i] = (int'(ss_sel) != i);
        end
    end

    // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        edge_d    = edge_q;
        idx_d     = idx_q;
        len_d     = len_q;
        tx_d      = tx_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        ss_d      = ss_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
`ifdef SPI_LSB_FIRST_EN
        lsb_d     = lsb_q;
`endif
        case (state_q)
            S_IDLE: begin
                sck_d  = cpol;
                div_d  = '0;
                edge_d = '0;
                if (start) begin
                    tx_d    = tx_data;
                    len_d   = xfer_len;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    ss_d    = ss_dec;
                    busy_d  = 1'b1;
                    rx_sh_d = '0;
                    state_d = S_LEAD;
`ifdef SPI_LSB_FIRST_EN
                    lsb_d   = lsb_first;
`endif
                    if (!cpha) begin
                        mosi_d = tx_data[first_idx];
                        idx_d  = step_idx(first_idx, start_lsb);
                    end else begin
                        idx_d  = first_idx;
                    end
                end
            end
            S_LEAD, S_XFER: begin
                div_d = tick ? '0 : div_q + DIV_W'(1);
                if (tick) begin
                    sck_d   = ~sck_q;
                    edge_d  = last_edge ? '0 : edge_q + EDGE_W'(1);
                    state_d = last_edge ? S_TRAIL : S_XFER;
                    if (sample_now) begin
                        rx_sh_d = rx_shifted;
                    end
                    if (drive_now) begin
                        mosi_d = tx_q[idx_q];
                        idx_d  = step_idx(idx_q, run_lsb);
                    end
                end
            end
            S_TRAIL: begin
                div_d = tick ? '0 : div_q + DIV_W'(1);
                if (tick) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    ss_d      = '1;
                    rx_data_d = rx_final;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            tx_q      <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            ss_q      <= '1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
`ifdef SPI_LSB_FIRST_EN
            lsb_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            tx_q      <= tx_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            ss_q      <= ss_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
`ifdef SPI_LSB_FIRST_EN
            lsb_q     <= lsb_d;
`endif
        end
    end

    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign ss      = ss_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;

endmodule
